// File: rtl/long_division_types_pkg.sv
// Shared types and helpers for the fixed-point long divider.
package long_division_types_pkg;

  typedef enum logic [1:0] {
    WAIT_DIVIDEND_E,
    WAIT_DIVISOR_E,
    DIVIDE_E,
    SEND_QUOTIENT_E
  } div_state_t;

  localparam int unsigned SAT_MAX_W = 64;

  // All-ones pattern of the given width, right-aligned in a SAT_MAX_W vector.
  function automatic logic [SAT_MAX_W-1:0] sat_ones(input int unsigned width);
    sat_ones = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i < width) sat_ones[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/long_division_axi.sv
// Sequential unsigned Q-format divider on AXI4-Stream: two-beat request
// (dividend, then divisor with tlast), one quotient beat with overflow in tuser.
module long_division_axi
  import long_division_types_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int Q_BITS_P         = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ing_tvalid,
  output logic                      ing_tready,
  input  logic [AXI_DATA_WIDTH_P-1:0] ing_tdata,
  input  logic                      ing_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0] ing_tid,
  output logic                      egr_tvalid,
  input  logic                      egr_tready,
  output logic [AXI_DATA_WIDTH_P-1:0] egr_tdata,
  output logic                      egr_tlast,
  output logic [AXI_ID_WIDTH_P-1:0] egr_tid,
  output logic                      egr_tuser
);

  localparam int unsigned N     = $unsigned(AXI_DATA_WIDTH_P);
  localparam int unsigned IW    = $unsigned(AXI_ID_WIDTH_P);
  localparam int unsigned Q     = $unsigned(Q_BITS_P);
  localparam int unsigned NQ    = N + Q;
  localparam int unsigned REM_W = N + 1;
  localparam int unsigned CMP_W = N + 2;
  localparam int unsigned CNT_W = $clog2(NQ + 1);

  div_state_t         state_q, state_d;
  logic [N-1:0]       dividend_q, dividend_d;
  logic [N-1:0]       divisor_q, divisor_d;
  logic [NQ-1:0]      num_q, num_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [IW-1:0]      id_q, id_d;
  logic               ing_tready_q, ing_tready_d;
  logic               egr_tvalid_q, egr_tvalid_d;
  logic [N-1:0]       egr_tdata_q, egr_tdata_d;
  logic               egr_tlast_q, egr_tlast_d;
  logic [IW-1:0]      egr_tid_q, egr_tid_d;
  logic               egr_tuser_q, egr_tuser_d;

  logic               ing_hs_c;
  logic               egr_hs_c;
  logic [CMP_W-1:0]   rem_shift_c;
  logic [CMP_W-1:0]   div_ext_c;
  logic               fits_c;

  assign ing_hs_c    = ing_tvalid && ing_tready_q;
  assign egr_hs_c    = egr_tvalid_q && egr_tready;
  // Bring the next numerator bit into the partial remainder.
  assign rem_shift_c = {rem_q, num_q[NQ-1]};
  assign div_ext_c   = {2'b00, divisor_q};
  assign fits_c      = (rem_shift_c >= div_ext_c);

  always_comb begin
    state_d      = state_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    num_d        = num_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    id_d         = id_q;
    egr_tvalid_d = egr_tvalid_q;
    egr_tdata_d  = egr_tdata_q;
    egr_tlast_d  = egr_tlast_q;
    egr_tid_d    = egr_tid_q;
    egr_tuser_d  = egr_tuser_q;

    case (state_q)
      WAIT_DIVIDEND_E: begin
        if (ing_hs_c && !ing_tlast) begin
          dividend_d = ing_tdata;
          state_d    = WAIT_DIVISOR_E;
        end
      end
      WAIT_DIVISOR_E: begin
        if (ing_hs_c) begin
          if (!ing_tlast) begin
            dividend_d = ing_tdata;
          end else begin
            divisor_d = ing_tdata;
            id_d      = ing_tid;
            num_d     = {dividend_q, {Q{1'b0}}};
            rem_d     = '0;
            cnt_d     = '0;
            ovf_d     = (ing_tdata == '0);
            state_d   = (ing_tdata == '0) ? SEND_QUOTIENT_E : DIVIDE_E;
          end
        end
      end
      DIVIDE_E: begin
        // Restoring step: quotient bits shift into the vacated numerator LSBs.
        rem_d = fits_c ? REM_W'(rem_shift_c - div_ext_c) : rem_shift_c[REM_W-1:0];
        num_d = {num_q[NQ-2:0], fits_c};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NQ - 1)) state_d = SEND_QUOTIENT_E;
      end
      SEND_QUOTIENT_E: begin
        if (!egr_tvalid_q) begin
          egr_tvalid_d = 1'b1;
          egr_tlast_d  = 1'b1;
          egr_tid_d    = id_q;
          if (ovf_q || (|num_q[NQ-1:N])) begin
            egr_tdata_d = N'(sat_ones(N));
            egr_tuser_d = 1'b1;
          end else begin
            egr_tdata_d = num_q[N-1:0];
            egr_tuser_d = 1'b0;
          end
        end else if (egr_hs_c) begin
          egr_tvalid_d = 1'b0;
          egr_tlast_d  = 1'b0;
          state_d      = WAIT_DIVIDEND_E;
        end
      end
      default: state_d = WAIT_DIVIDEND_E;
    endcase

    ing_tready_d = (state_d == WAIT_DIVIDEND_E) || (state_d == WAIT_DIVISOR_E);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_DIVIDEND_E;
      dividend_q   <= '0;
      divisor_q    <= '0;
      num_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      id_q         <= '0;
      ing_tready_q <= 1'b0;
      egr_tvalid_q <= 1'b0;
      egr_tdata_q  <= '0;
      egr_tlast_q  <= 1'b0;
      egr_tid_q    <= '0;
      egr_tuser_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      num_q        <= num_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      id_q         <= id_d;
      ing_tready_q <= ing_tready_d;
      egr_tvalid_q <= egr_tvalid_d;
      egr_tdata_q  <= egr_tdata_d;
      egr_tlast_q  <= egr_tlast_d;
      egr_tid_q    <= egr_tid_d;
      egr_tuser_q  <= egr_tuser_d;
    end
  end

  assign ing_tready = ing_tready_q;
  assign egr_tvalid = egr_tvalid_q;
  assign egr_tdata  = egr_tdata_q;
  assign egr_tlast  = egr_tlast_q;
  assign egr_tid    = egr_tid_q;
  assign egr_tuser  = egr_tuser_q;

endmodule
